// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N byte requesters.
// Optional source-ID header byte before each payload: define UART_ARB_ID_TAG_EN.
module uart_tx_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic [W-1:0]   tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           busy,
    output logic [3:0]     grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    localparam logic [4:0] N_L = 5'(N);

    if ((N < 2) || (N > 16)) begin : g_bad_n
        $error("uart_tx_arbiter: N must be in 2..16");
    end

`ifdef UART_ARB_ID_TAG_EN
    if (W != 8) begin : g_bad_w
        $error("uart_tx_arbiter: W must be 8 when the ID tag is enabled");
    end
`endif

    // Index following idx, wrapping at N (N need not be a power of two).
    function automatic logic [3:0] f_inc_mod(input logic [3:0] idx);
        logic [4:0] nxt;
        nxt = {1'b0, idx} + 5'd1;
        if (nxt >= N_L) begin
            nxt = 5'd0;
        end else begin
            nxt = nxt;
        end
        return nxt[3:0];
    endfunction

    state_e         state_q, state_d;
    logic [3:0]     ptr_q, ptr_d;
    logic [W-1:0]   hold_q, hold_d;
    logic [3:0]     grant_id_q, grant_id_d;
    logic           tx_valid_q, tx_valid_d;
    logic [W-1:0]   tx_data_q, tx_data_d;
    logic           busy_q, busy_d;

    logic [15:0]    valid_ext_s;
    logic           found_s;
    logic [3:0]     win_s;
    logic [4:0]     idx_s;
    logic [W-1:0]   sel_data_s;
    logic [15:0]    ready_ext_s;

    // Round-robin search from ptr_q; first valid requester wins.
    always_comb begin
        valid_ext_s = 16'(req_valid);
        found_s     = 1'b0;
        win_s       = 4'd0;
        idx_s       = 5'd0;
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr_q} + 5'(k);
            if (idx_s >= N_L) begin
                idx_s = idx_s - N_L;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && valid_ext_s[idx_s[3:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[3:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner's byte mux and one-hot acceptance (only while IDLE).
    always_comb begin
        sel_data_s  = {W{1'b0}};
        ready_ext_s = 16'd0;
        for (int i = 0; i < N; i++) begin
            if (win_s == 4'(i)) begin
                sel_data_s = req_data[i*W +: W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        if ((state_q == ST_IDLE) && found_s) begin
            ready_ext_s[win_s] = 1'b1;
        end else begin
            ready_ext_s = 16'd0;
        end
    end

    assign req_ready = ready_ext_s[N-1:0];

    // Next-state, pointer and latched-byte logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    hold_d     = sel_data_s;
                    grant_id_d = win_s;
`ifdef UART_ARB_ID_TAG_EN
                    state_d    = ST_HDR;
`else
                    state_d    = ST_DATA;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef UART_ARB_ID_TAG_EN
            ST_HDR: begin
                if (tx_ready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
`endif
            ST_DATA: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = f_inc_mod(grant_id_q);
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they hold steady under backpressure.
    always_comb begin
        tx_valid_d = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        tx_data_d  = tx_data_q;
        case (state_d)
`ifdef UART_ARB_ID_TAG_EN
            ST_HDR: begin
                tx_data_d = {4'hA, grant_id_d};
            end
`endif
            ST_DATA: begin
                tx_data_d = hold_d;
            end
            default: begin
                tx_data_d = tx_data_q;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 4'd0;
            hold_q     <= {W{1'b0}};
            grant_id_q <= 4'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= {W{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            grant_id_q <= grant_id_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: behavioural round-robin model, randomized and directed stimulus.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
`ifdef UART_ARB_ID_TAG_EN
    localparam int TAG = 1;
`else
    localparam int TAG = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           busy;
    logic [3:0]     grant_id;

    logic [2:0]     v3;
    logic [23:0]    d3;
    logic [2:0]     rr3;
    logic [7:0]     td3;
    logic           tv3;
    logic           rdy3;
    logic           busy3;
    logic [3:0]     gid3;

    int n_tests = 0;
    int n_fail  = 0;
    int rst_cnt = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .W(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arbiter #(.N(3), .W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
        .req_ready(rr3), .tx_data(td3), .tx_valid(tv3),
        .tx_ready(rdy3), .busy(busy3), .grant_id(gid3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pointer, bytes still owed for the current grant, last grantee.
    int m_ptr = 0;
    int m_out = 0;
    int m_gid = 0;
    int m_rst_seen = 0;
    always @(negedge clk) begin
        logic [N-1:0] exp_rr;
        int  win;
        bit  found;
        if (!rst_n || (m_rst_seen != rst_cnt)) begin
            m_ptr = 0; m_out = 0; m_gid = 0;
            exp_q.delete();
            m_rst_seen = rst_cnt;
        end
        exp_rr = '0;
        found  = 1'b0;
        win    = 0;
        if (m_out == 0) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    win   = (m_ptr + k) % N;
                end
            end
        end
        if (found) exp_rr[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("tx_valid", 32'(tx_valid), 32'(m_out > 0));
        chk("busy", 32'(busy), 32'(m_out > 0));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        if (rst_n) begin
            if (m_out == 0) begin
                if (found) begin
                    if (TAG == 1) exp_q.push_back({4'hA, 4'(win)});
                    exp_q.push_back(req_data[win*W +: W]);
                    m_out = 1 + TAG;
                    m_gid = win;
                end
            end else if (tx_ready) begin
                m_out--;
                if (m_out == 0) m_ptr = (m_gid + 1) % N;
            end
        end
    end

    // Monitor: pops expected bytes on each accepted transfer, checks stability while stalled.
    bit           stalled = 1'b0;
    logic [W-1:0] stall_data = '0;
    int           mon_rst_seen = 0;
    always @(negedge clk) begin
        if (mon_rst_seen != rst_cnt) begin
            stalled = 1'b0;
            mon_rst_seen = rst_cnt;
        end
        if (stalled) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'(stall_data));
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_tx: got byte %0h with no expected byte queued", tx_data);
            end else begin
                chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
        stalled    = tx_valid && !tx_ready;
        stall_data = tx_data;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; tx_ready = 1'b1;
        v3 = '0; d3 = '0; rdy3 = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        chk("reset_tx_data", 32'(tx_data), 32'd0);

        // Single requester 2, then all valid: next grant must be 3.
        req_data = {8'h43, 8'h32, 8'h5C, 8'h10};
        req_valid = 4'b0100; cyc(1);
        req_valid = 4'b0000; cyc(3);
        req_valid = 4'b1111; cyc(1);
        req_valid = 4'b0000; cyc(3);

        // All four valid continuously: five grants 0,1,2,3,0.
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111; cyc(5 * (2 + TAG));
        req_valid = 4'b0000; cyc(3);

        // Backpressure for 7 cycles with byte E7.
        req_data = {8'h00, 8'h00, 8'hE7, 8'h00};
        tx_ready = 1'b0; req_valid = 4'b0010; cyc(1);
        req_valid = 4'b0000; cyc(7);
        tx_ready = 1'b1; cyc(4);

        // Reset pulse mid-transfer, then lowest valid index wins.
        req_data = {8'h3C, 8'h66, 8'h55, 8'h00};
        tx_ready = 1'b0; req_valid = 4'b1000; cyc(1);
        req_valid = 4'b0000; cyc(1 + TAG);
        #2;
        chk("pre_rst_valid", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        #0.5;
        chk("async_rst_valid", 32'(tx_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        #0.5;
        rst_n = 1'b1;
        rst_cnt++;
        tx_ready = 1'b1; req_valid = 4'b0110;
        cyc(1);
        req_valid = 4'b0000; cyc(4);

        // N=3 wrap: requester 2 served, then 3'b011 must go to requester 0.
        d3 = {8'hC2, 8'hB1, 8'hA0};
        v3 = 3'b100;
        @(negedge clk);
        chk("n3_ready_2", 32'(rr3), 32'b100);
        @(posedge clk); #1;
        v3 = 3'b000;
        @(negedge clk);
        chk("n3_valid", 32'(tv3), 32'd1);
        chk("n3_first_byte", 32'(td3), (TAG == 1) ? 32'hA2 : 32'hC2);
        if (TAG == 1) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("n3_payload", 32'(td3), 32'hC2);
        end
        @(posedge clk); #1;
        v3 = 3'b011;
        @(negedge clk);
        chk("n3_wrap_ready", 32'(rr3), 32'b001);
        @(posedge clk); #1;
        v3 = 3'b000;
        @(negedge clk);
        chk("n3_wrap_gid", 32'(gid3), 32'd0);
        cyc(4);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
            for (int b = 0; b < N; b++) req_data[b*W +: W] = W'($urandom);
            tx_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end

        req_valid = '0; tx_ready = 1'b1;
        cyc(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
